// File: rtl/trdb_itype_classifier_if.sv
// Retirement-side inputs and packet-emitter-side outputs of the itype classifier.
interface trdb_itype_classifier_if #(
    parameter int XLEN    = 32,
    parameter int IADDR_W = 32,
    parameter int ITYPE_W = 4
);
    logic               valid_i;
    logic [XLEN-1:0]    inst_data_i;
    logic               compressed_i;
    logic [IADDR_W-1:0] iaddr_i;
    logic               exception_i;
    logic               interrupt_i;
    logic               eret_i;
    logic               flush_i;

    logic               valid_o;
    logic [IADDR_W-1:0] iaddr_o;
    logic [ITYPE_W-1:0] itype_o;
    logic               ilastsize_o;
    logic               branch_o;
    logic               branch_taken_o;
    logic               updiscon_o;
    logic               partial_o;

    modport master (
        output valid_i, inst_data_i, compressed_i, iaddr_i,
               exception_i, interrupt_i, eret_i, flush_i,
        input  valid_o, iaddr_o, itype_o, ilastsize_o,
               branch_o, branch_taken_o, updiscon_o, partial_o
    );

    modport slave (
        input  valid_i, inst_data_i, compressed_i, iaddr_i,
               exception_i, interrupt_i, eret_i, flush_i,
        output valid_o, iaddr_o, itype_o, ilastsize_o,
               branch_o, branch_taken_o, updiscon_o, partial_o
    );
endinterface

// File: rtl/trdb_itype_classifier.sv
// Pipelined E-Trace itype classifier: holds one retired instruction (tc) and
// classifies it once its successor (nc) arrives, or on a flush drain.
module trdb_itype_classifier #(
    parameter int XLEN    = 32,
    parameter int IADDR_W = 32,
    parameter int ITYPE_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    trdb_itype_classifier_if.slave bus
);
    generate
        if (ITYPE_W != 3 && ITYPE_W != 4) begin : g_bad_itype_w
            $error("trdb_itype_classifier: ITYPE_W must be 3 or 4");
        end
        if (XLEN < 32) begin : g_bad_xlen
            $error("trdb_itype_classifier: XLEN must be at least 32");
        end
    endgenerate

    // Only opcode/rd/funct3/rs1 bits matter for classification, so the upper
    // instruction bits are not held.
    typedef struct packed {
        logic               valid;
        logic [19:0]        data;
        logic               compressed;
        logic [IADDR_W-1:0] iaddr;
        logic               exception;
        logic               interrupt;
        logic               eret;
    } held_t;

    held_t tc;
    logic  flush_pend;

    logic unused_data_hi;
    assign unused_data_hi = ^bus.inst_data_i[XLEN-1:20];

    logic [15:0]        cins;
    logic               is_br, is_jal, is_jalr;
    logic [4:0]         j_rd, j_rs1;
    logic               rd_link, rs1_link;
    logic               drain, emit, taken, updiscon;
    logic [IADDR_W-1:0] fall_addr;
    logic [3:0]         jump_code, itype_full;

    // Decode the held instruction into branch, jal-class and jalr-class with
    // effective rd/rs1 (compressed forms imply rd = x0 or x1).
    always_comb begin
        cins    = tc.data[15:0];
        is_br   = 1'b0;
        is_jal  = 1'b0;
        is_jalr = 1'b0;
        j_rd    = 5'd0;
        j_rs1   = 5'd0;
        if (tc.compressed) begin
            j_rs1 = cins[11:7];
            // c.beqz / c.bnez
            if (cins[1:0] == 2'b01 && cins[15:14] == 2'b11)
                is_br = 1'b1;
            // c.j (101) / c.jal (001)
            if (cins[1:0] == 2'b01 && cins[14:13] == 2'b01) begin
                is_jal = 1'b1;
                j_rd   = cins[15] ? 5'd0 : 5'd1;
            end
            // c.jr / c.jalr; rs1 = x0 encodes something else
            if (cins[1:0] == 2'b10 && cins[15:13] == 3'b100 &&
                cins[6:2] == 5'd0 && cins[11:7] != 5'd0) begin
                is_jalr = 1'b1;
                j_rd    = cins[12] ? 5'd1 : 5'd0;
            end
        end else begin
            j_rd    = tc.data[11:7];
            j_rs1   = tc.data[19:15];
            // all funct3 values: base branches plus p.beqimm/p.bneimm
            is_br   = (tc.data[6:0] == 7'b1100011);
            is_jal  = (tc.data[6:0] == 7'b1101111);
            is_jalr = (tc.data[6:0] == 7'b1100111) && (tc.data[14:12] == 3'b000);
        end
        rd_link  = (j_rd == 5'd1) || (j_rd == 5'd5);
        rs1_link = (j_rs1 == 5'd1) || (j_rs1 == 5'd5);
    end

    // Classify tc against the incoming instruction; a drain has no successor,
    // so a drained branch is reported as not taken.
    always_comb begin
        drain     = !bus.valid_i;
        emit      = tc.valid && (bus.valid_i || bus.flush_i || flush_pend);
        fall_addr = tc.iaddr + (tc.compressed ? IADDR_W'(2) : IADDR_W'(4));
        taken     = is_br && !drain && (fall_addr != bus.iaddr_i);
        updiscon  = is_jalr || tc.exception || tc.interrupt || tc.eret;

        jump_code = 4'd0;
        if (is_jalr) begin
            if (ITYPE_W == 3)                              jump_code = 4'd6;
            else if (rd_link && rs1_link && j_rs1 != j_rd) jump_code = 4'd12;
            else if (rd_link)                              jump_code = 4'd8;
            else if (rs1_link)                             jump_code = 4'd13;
            else if (j_rd == 5'd0)                         jump_code = 4'd10;
            else                                           jump_code = 4'd14;
        end else if (is_jal && ITYPE_W == 4) begin
            if (rd_link)           jump_code = 4'd9;
            else if (j_rd == 5'd0) jump_code = 4'd11;
            else                   jump_code = 4'd15;
        end

        if (tc.interrupt)      itype_full = 4'd2;
        else if (tc.exception) itype_full = 4'd1;
        else if (tc.eret)      itype_full = 4'd3;
        else if (is_br)        itype_full = taken ? 4'd5 : 4'd4;
        else                   itype_full = jump_code;
    end

    // Output registers update only on an emit; tc/flush_pend track the window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tc                 <= '0;
            flush_pend         <= 1'b0;
            bus.valid_o        <= 1'b0;
            bus.iaddr_o        <= '0;
            bus.itype_o        <= '0;
            bus.ilastsize_o    <= 1'b0;
            bus.branch_o       <= 1'b0;
            bus.branch_taken_o <= 1'b0;
            bus.updiscon_o     <= 1'b0;
            bus.partial_o      <= 1'b0;
        end else begin
            bus.valid_o <= emit;
            if (emit) begin
                bus.iaddr_o        <= tc.iaddr;
                bus.itype_o        <= itype_full[ITYPE_W-1:0];
                bus.ilastsize_o    <= !tc.compressed;
                bus.branch_o       <= is_br;
                bus.branch_taken_o <= taken;
                bus.updiscon_o     <= updiscon;
                bus.partial_o      <= drain;
            end
            if (bus.valid_i) begin
                tc.valid      <= 1'b1;
                tc.data       <= bus.inst_data_i[19:0];
                tc.compressed <= bus.compressed_i;
                tc.iaddr      <= bus.iaddr_i;
                tc.exception  <= bus.exception_i;
                tc.interrupt  <= bus.interrupt_i;
                tc.eret       <= bus.eret_i;
                if (bus.flush_i)
                    flush_pend <= 1'b1;
            end else if (emit) begin
                tc.valid   <= 1'b0;
                flush_pend <= 1'b0;
            end else if (!tc.valid) begin
                flush_pend <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_trdb_itype_classifier.sv
// Bench for trdb_itype_classifier: ITYPE_W=4 and ITYPE_W=3 instances driven in
// lockstep, checked against a mnemonic-table reference model.
module tb_trdb_itype_classifier;
    localparam int K_OTHER = 0, K_BR = 1, K_JAL = 2, K_JALR = 3;

    typedef struct {
        logic [31:0] data;
        logic        c;
        logic [31:0] addr;
        logic        exc, irq, eret;
    } ins_t;

    typedef struct {
        logic        valid;
        logic [31:0] iaddr;
        logic [3:0]  it4;
        logic [2:0]  it3;
        logic        size, br, tk, upd, part;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_c = 1'b0, in_exc = 1'b0, in_irq = 1'b0;
    logic        in_eret = 1'b0, in_flush = 1'b0;
    logic [31:0] in_data = '0, in_addr = '0;

    trdb_itype_classifier_if #(.XLEN(32), .IADDR_W(32), .ITYPE_W(4)) bus4 ();
    trdb_itype_classifier_if #(.XLEN(32), .IADDR_W(32), .ITYPE_W(3)) bus3 ();

    assign bus4.valid_i = in_valid;  assign bus3.valid_i = in_valid;
    assign bus4.inst_data_i = in_data; assign bus3.inst_data_i = in_data;
    assign bus4.compressed_i = in_c; assign bus3.compressed_i = in_c;
    assign bus4.iaddr_i = in_addr;   assign bus3.iaddr_i = in_addr;
    assign bus4.exception_i = in_exc; assign bus3.exception_i = in_exc;
    assign bus4.interrupt_i = in_irq; assign bus3.interrupt_i = in_irq;
    assign bus4.eret_i = in_eret;    assign bus3.eret_i = in_eret;
    assign bus4.flush_i = in_flush;  assign bus3.flush_i = in_flush;

    trdb_itype_classifier #(.XLEN(32), .IADDR_W(32), .ITYPE_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus4.slave));
    trdb_itype_classifier #(.XLEN(32), .IADDR_W(32), .ITYPE_W(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus3.slave));

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    ins_t m_tc;
    logic m_vld = 1'b0;
    logic m_pend = 1'b0;
    exp_t m_out = '{default: '0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Identify the instruction by mnemonic mask/match tables.
    function automatic void decode(input ins_t i, output int kind, output int rd, output int rs1);
        logic [31:0] d;
        logic [15:0] h;
        d = i.data;
        h = i.data[15:0];
        kind = K_OTHER; rd = 0; rs1 = 0;
        if (!i.c) begin
            // beq bne p.beqimm p.bneimm blt bge bltu bgeu
            if ((d & 32'h707f) inside {32'h0063, 32'h1063, 32'h2063, 32'h3063,
                                       32'h4063, 32'h5063, 32'h6063, 32'h7063})
                kind = K_BR;
            else if ((d & 32'h7f) == 32'h6f) begin
                kind = K_JAL; rd = int'(d[11:7]);
            end else if ((d & 32'h707f) == 32'h67) begin
                kind = K_JALR; rd = int'(d[11:7]); rs1 = int'(d[19:15]);
            end
        end else begin
            if ((h & 16'he003) inside {16'hc001, 16'he001})
                kind = K_BR;
            else if ((h & 16'he003) == 16'ha001) begin
                kind = K_JAL; rd = 0;
            end else if ((h & 16'he003) == 16'h2001) begin
                kind = K_JAL; rd = 1;
            end else if ((h & 16'hf07f) == 16'h8002 && h[11:7] != 5'd0) begin
                kind = K_JALR; rd = 0; rs1 = int'(h[11:7]);
            end else if ((h & 16'hf07f) == 16'h9002 && h[11:7] != 5'd0) begin
                kind = K_JALR; rd = 1; rs1 = int'(h[11:7]);
            end
        end
    endfunction

    function automatic exp_t ref_emit(input ins_t i, input logic [31:0] nxt, input logic drain);
        exp_t o;
        int kind, rd, rs1;
        logic lrd, lrs, jmp;
        logic [31:0] fall;
        decode(i, kind, rd, rs1);
        lrd = (rd == 1) || (rd == 5);
        lrs = (rs1 == 1) || (rs1 == 5);
        fall = i.addr + (i.c ? 32'd2 : 32'd4);
        o.valid = 1'b1;
        o.iaddr = i.addr;
        o.size = !i.c;
        o.part = drain;
        o.br = (kind == K_BR);
        o.tk = o.br && !drain && (fall != nxt);
        o.upd = (kind == K_JALR) || i.exc || i.irq || i.eret;
        jmp = 1'b0;
        if (i.irq) o.it4 = 2;
        else if (i.exc) o.it4 = 1;
        else if (i.eret) o.it4 = 3;
        else if (o.br) o.it4 = o.tk ? 4'd5 : 4'd4;
        else if (kind == K_JALR) begin
            jmp = 1'b1;
            if (lrd && lrs && rs1 != rd) o.it4 = 12;
            else if (lrd) o.it4 = 8;
            else if (lrs) o.it4 = 13;
            else if (rd == 0) o.it4 = 10;
            else o.it4 = 14;
        end else if (kind == K_JAL) begin
            jmp = 1'b1;
            if (lrd) o.it4 = 9;
            else if (rd == 0) o.it4 = 11;
            else o.it4 = 15;
        end else o.it4 = 0;
        if (!jmp) o.it3 = o.it4[2:0];
        else o.it3 = (kind == K_JALR) ? 3'd6 : 3'd0;
        return o;
    endfunction

    function automatic ins_t mk(input logic [31:0] d, input logic c, input logic [31:0] a,
                                input logic exc = 0, input logic irq = 0, input logic er = 0);
        ins_t i;
        i.data = d; i.c = c; i.addr = a; i.exc = exc; i.irq = irq; i.eret = er;
        return i;
    endfunction

    task automatic cmp_all();
        chk("valid4", bus4.valid_o, m_out.valid);
        chk("valid3", bus3.valid_o, m_out.valid);
        chk("iaddr", bus4.iaddr_o, m_out.iaddr);
        chk("iaddr3", bus3.iaddr_o, m_out.iaddr);
        chk("itype4", bus4.itype_o, m_out.it4);
        chk("itype3", bus3.itype_o, m_out.it3);
        chk("ilastsize", bus4.ilastsize_o, m_out.size);
        chk("branch", bus4.branch_o, m_out.br);
        chk("taken", bus4.branch_taken_o, m_out.tk);
        chk("updiscon", bus4.updiscon_o, m_out.upd);
        chk("partial", bus4.partial_o, m_out.part);
    endtask

    // Drive one cycle, advance the model, check after the edge.
    task automatic step(input logic v, input ins_t i, input logic fl);
        in_valid = v; in_data = i.data; in_c = i.c; in_addr = i.addr;
        in_exc = i.exc; in_irq = i.irq; in_eret = i.eret; in_flush = fl;
        m_out.valid = 1'b0;
        if (v) begin
            if (m_vld) m_out = ref_emit(m_tc, i.addr, 1'b0);
            m_tc = i;
            m_vld = 1'b1;
            if (fl) m_pend = 1'b1;
        end else if ((fl || m_pend) && m_vld) begin
            m_out = ref_emit(m_tc, 32'h0, 1'b1);
            m_vld = 1'b0;
            m_pend = 1'b0;
        end else if (!m_vld) begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic idle(input logic fl);
        step(1'b0, mk(32'h0, 1'b0, 32'h0), fl);
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic ins_t rand_ins(input logic [31:0] a);
        logic [31:0] d;
        logic c;
        d = $urandom;
        c = 1'b0;
        case ($urandom_range(0, 8))
            0: d[6:0] = 7'h63;
            1: begin c = 1; d[15:13] = 3'($urandom_range(6, 7)); d[1:0] = 2'b01; end
            2: begin d[6:0] = 7'h6f; d[11:7] = pick_reg(); end
            3: begin d[6:0] = 7'h67; d[14:12] = 3'd0; d[11:7] = pick_reg(); d[19:15] = pick_reg(); end
            4: begin c = 1; d[15:13] = $urandom_range(0, 1) ? 3'b101 : 3'b001; d[1:0] = 2'b01; end
            5: begin c = 1; d[15:13] = 3'b100; d[12] = 1'($urandom); d[6:2] = 5'd0;
                     d[11:7] = pick_reg(); d[1:0] = 2'b10; end
            6: d[1:0] = 2'b11;
            7: begin c = 1; d[1:0] = 2'($urandom_range(0, 2)); end
            default: d[6:0] = 7'h13;
        endcase
        return mk(d, c, a, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0);
    endfunction

    initial begin
        ins_t r;
        logic [31:0] last_a;
        logic last_c;
        logic [31:0] a;

        #2;
        cmp_all();                      // reset state: everything 0
        #15 rst_n = 1'b1;

        // taken branch: beq at 0x100, next at 0x200
        step(1, mk(32'h0000_0063, 0, 32'h100), 0);
        chk("tp_idle_after_load", bus4.valid_o, 1'b0);
        step(1, mk(32'h0000_0013, 0, 32'h200), 0);
        chk("tp_taken_itype", bus4.itype_o, 4'd5);
        chk("tp_taken_flag", bus4.branch_taken_o, 1'b1);
        chk("tp_taken_iaddr", bus4.iaddr_o, 32'h100);

        // wrap-around: c.bnez at 0xFFFFFFFE, next at 0
        step(1, mk(32'h0000_e001, 1, 32'hFFFF_FFFE), 0);
        step(1, mk(32'h0000_0013, 0, 32'h0), 0);
        chk("tp_wrap_itype", bus4.itype_o, 4'd4);
        chk("tp_wrap_taken", bus4.branch_taken_o, 1'b0);
        chk("tp_wrap_size", bus4.ilastsize_o, 1'b0);

        // jump classes
        step(1, mk(32'h0002_80e7, 0, 32'h1000), 0);   // jalr x1, 0(x5)
        step(1, mk(32'h0000_8067, 0, 32'h2000), 0);   // jalr x0, 0(x1)
        chk("tp_coswap4", bus4.itype_o, 4'd12);
        chk("tp_coswap3", bus3.itype_o, 3'd6);
        step(1, mk(32'h0000_00ef, 0, 32'h3000), 0);   // jal x1
        chk("tp_return4", bus4.itype_o, 4'd13);
        chk("tp_return3", bus3.itype_o, 3'd6);
        step(1, mk(32'h0000_8382, 1, 32'h4000), 0);   // c.jr x7
        chk("tp_call4", bus4.itype_o, 4'd9);
        chk("tp_call3", bus3.itype_o, 3'd0);
        step(1, mk(32'h0000_0013, 0, 32'h5000), 0);
        chk("tp_cjr4", bus4.itype_o, 4'd10);
        chk("tp_cjr3", bus3.itype_o, 3'd6);
        chk("tp_cjr_updiscon", bus4.updiscon_o, 1'b1);

        // priority: beq with exception and interrupt
        step(1, mk(32'h0000_0063, 0, 32'h6000, 1, 1, 0), 0);
        step(1, mk(32'h0000_0013, 0, 32'h6004), 0);
        chk("tp_prio_itype", bus4.itype_o, 4'd2);
        chk("tp_prio_updiscon", bus4.updiscon_o, 1'b1);
        chk("tp_prio_branch", bus4.branch_o, 1'b1);

        // flush with valid: A emitted, then B drained with partial, then nothing
        step(1, mk(32'h0000_0013, 0, 32'h7000), 0);   // A
        step(1, mk(32'h0000_0063, 0, 32'h7004), 1);   // B = beq, flush
        chk("tp_flush_a_iaddr", bus4.iaddr_o, 32'h7000);
        chk("tp_flush_a_partial", bus4.partial_o, 1'b0);
        idle(0);
        chk("tp_flush_b_valid", bus4.valid_o, 1'b1);
        chk("tp_flush_b_partial", bus4.partial_o, 1'b1);
        chk("tp_flush_b_itype", bus4.itype_o, 4'd4);
        chk("tp_flush_b_taken", bus4.branch_taken_o, 1'b0);
        idle(0);
        chk("tp_flush_quiet", bus4.valid_o, 1'b0);
        idle(1);                                      // flush on empty: no-op
        chk("tp_flush_empty", bus4.valid_o, 1'b0);

        // reset mid-stream with tc valid
        step(1, mk(32'h0000_0063, 0, 32'h8000), 0);
        #2 rst_n = 1'b0;
        m_vld = 1'b0; m_pend = 1'b0; m_out = '{default: '0};
        #1 cmp_all();
        @(posedge clk);
        #3 rst_n = 1'b1;
        step(1, mk(32'h0000_0013, 0, 32'h9000), 0);
        chk("tp_rst_novalid", bus4.valid_o, 1'b0);
        chk("tp_rst_iaddr", bus4.iaddr_o, 32'h0);

        // randomized traffic
        last_a = 32'h9000;
        last_c = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle($urandom_range(0, 3) == 0);
            end else begin
                if ($urandom_range(0, 1) != 0) a = last_a + (last_c ? 32'd2 : 32'd4);
                else a = $urandom & 32'hFFFF_FFFE;
                r = rand_ins(a);
                step(1, r, $urandom_range(0, 7) == 0);
                last_a = a;
                last_c = r.c;
            end
        end
        idle(1);
        idle(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
